qspi_xip_ctrl: RTL
==================

// Module: qspi_xip_ctrl
// PURPOSE
//  Execute-in-place front end for the QSPI flash/PSRAM master. Arbitrates CPU instruction-fetch
//  and data load/store ports onto a single master. Keeps a paused sequential instruction stream
//  open (CS low) so the next sequential fetch needs only a one-cycle 'cont' resume.
//  Sits between CPU bus adapters (upstream) and spi_master (downstream).
// PARAMETERS
//  STREAM_IDLE_MAX  64  cycles a paused stream may idle before the controller closes it with m_stop
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  i_req          in   1   instruction fetch request; held until i_rvalid
//  i_addr         in   24  fetch byte address; bits[1:0] ignored (forced 0)
//  i_rdata        out  32  fetched word, valid with i_rvalid
//  i_rvalid       out  1   one-cycle fetch completion pulse
//  d_req          in   1   data request; held until d_ack
//  d_we           in   1   1=store, 0=load
//  d_addr         in   24  data byte address; bits[1:0] forced 0
//  d_wdata        in   32  store data
//  d_rdata        out  32  load data, valid with d_ack
//  d_ack          out  1   one-cycle data completion pulse (loads and stores)
//  m_start        out  1   to master: start transaction (1-cycle pulse)
//  m_stop         out  1   to master: abort/close transaction (1-cycle pulse)
//  m_cont         out  1   to master: resume paused sequential read (1-cycle pulse)
//  m_write_enable out  1   to master: 1=write
//  m_is_instr     out  1   to master: 1=instruction stream (master pauses after word)
//  m_addr         out  24  to master: word address
//  m_data_len     out  6   to master: constant 6'd32
//  m_data_in      out  32  to master: store data
//  m_data_out     in   32  from master: read data
//  m_done         in   1   from master: completion (may stay high 2 cycles)
// BEHAVIOUR
//  - Reset: all outputs 0 except m_data_len=32; FSM=IDLE; stream_valid=0; idle counter=0.
//  - Completion = rising edge of m_done (m_done & ~done_q); m_done level never used directly.
//  - Request fields are latched when a request is accepted; master outputs stay stable until completion.
//  - States: IDLE, ISSUE, WAIT_I, STREAM, STOP, WAIT_D.
//  - IDLE: d_req has priority over i_req. Accepted request -> ISSUE.
//  - ISSUE: m_start=1 for one cycle with m_addr/m_is_instr/m_write_enable valid.
//    Then -> WAIT_I (instr) or WAIT_D (data).
//  - WAIT_I: on completion, i_rdata<=m_data_out, i_rvalid=1 next cycle, next_addr<=addr+4
//    (24-bit wrap 0xFFFFFC->0x000000), stream_valid=1 -> STREAM.
//  - WAIT_D: on completion, d_rdata<=m_data_out (loads; stores leave d_rdata unchanged), d_ack=1
//    -> IDLE.
//  - STREAM (master paused, CS low), evaluated in priority order:
//    - d_req -> STOP, target data.
//    - i_req && i_addr==next_addr -> m_cont=1 one cycle -> WAIT_I.
//    - i_req mismatch -> STOP, target instr.
//    - idle counter reaches STREAM_IDLE_MAX -> STOP, target none.
//  - STOP: m_stop=1 exactly one cycle; stream_valid<=0.
//    Next state: ISSUE for the pending target, else IDLE. Start is never in the same cycle as stop.
//  - Idle counter: increments each STREAM cycle without i_req/d_req; cleared on leaving STREAM.
//  - Simultaneous i_req and d_req: data served first; fetch served after d_ack
//    (fetch then needs a new start).
//  - Fetch-to-fetch latency in stream: i_req sampled -> m_cont next cycle; i_rvalid 1 cycle after
//    the m_done edge.
//  - A request dropped before completion is a protocol violation; behaviour is undefined.
//  - Async reset mid-transaction: outputs return to reset values immediately.
//    The master is reset by the same rst_n.
// TESTING
//  1. Reset, i_req@0x000100 -> exactly one m_start, m_is_instr=1, m_addr=0x000100;
//     i_rvalid with the model word.
//  2. Fetches 0x100,0x104,0x108 -> one m_start then two m_cont pulses, no m_stop;
//     three i_rvalid pulses in order.
//  3. Stream at next 0x10C, fetch 0x200 -> m_stop 1 cycle, then m_start@0x200 the following cycle.
//  4. In stream, d_req load@0x004000 together with i_req@0x10C -> stop, load first
//     (d_ack, d_rdata correct), then fetch via new m_start.
//  5. Store d_we=1 d_wdata=0xDEADBEEF@0x000800 -> m_write_enable=1, m_is_instr=0,
//     m_data_in=0xDEADBEEF; one d_ack even when m_done is high 2 cycles.
//  6. Stream idle STREAM_IDLE_MAX cycles -> single m_stop, IDLE; fetch at 0xFFFFFC then
//     0x000000 -> cont used (wrap).

Source files
------------

// File: rtl/qspi_xip_ctrl_if.sv
// Bus bundle for the XIP controller: CPU fetch/data ports plus the spi_master control lines.
// The controller takes the slave modport; the environment driving it takes the master modport.
interface qspi_xip_ctrl_if;
    logic        i_req;
    logic [23:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_rvalid;

    logic        d_req;
    logic        d_we;
    logic [23:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;

    logic        m_start;
    logic        m_stop;
    logic        m_cont;
    logic        m_write_enable;
    logic        m_is_instr;
    logic [23:0] m_addr;
    logic [5:0]  m_data_len;
    logic [31:0] m_data_in;
    logic [31:0] m_data_out;
    logic        m_done;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_data_out, m_done,
        output i_rdata, i_rvalid, d_rdata, d_ack,
        output m_start, m_stop, m_cont, m_write_enable, m_is_instr, m_addr, m_data_len,
        output m_data_in
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_data_out, m_done,
        input  i_rdata, i_rvalid, d_rdata, d_ack,
        input  m_start, m_stop, m_cont, m_write_enable, m_is_instr, m_addr, m_data_len,
        input  m_data_in
    );
endinterface

// File: rtl/qspi_xip_ctrl.sv
// XIP front end: arbitrates fetch and data ports onto one spi_master and keeps a paused
// sequential instruction stream open so the next sequential fetch only needs a 'cont' pulse.
module qspi_xip_ctrl #(
    parameter int unsigned STREAM_IDLE_MAX = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    qspi_xip_ctrl_if.slave bus
);
    localparam int unsigned CntW = $clog2(STREAM_IDLE_MAX + 1);

    typedef enum logic [2:0] {StIdle, StIssue, StWaitI, StStream, StStop, StWaitD} state_e;
    typedef enum logic [1:0] {TgtNone, TgtInstr, TgtData} target_e;

    state_e          state_q, state_d;
    target_e         target_q, target_d;
    logic            done_q;
    logic [23:0]     addr_q, addr_d;
    logic [23:0]     next_addr_q, next_addr_d;
    logic            we_q, we_d;
    logic            is_instr_q, is_instr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic            stream_valid_q, stream_valid_d;
    logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
    logic            cont_q, cont_d;
    logic [31:0]     i_rdata_q, i_rdata_d;
    logic [31:0]     d_rdata_q, d_rdata_d;
    logic            i_rvalid_q, i_rvalid_d;
    logic            d_ack_q, d_ack_d;

    logic done_edge, i_req_eff, d_req_eff, i_match;
    logic unused_addr_lsbs;

    assign done_edge = bus.m_done & ~done_q;
    // A requester may still hold its request during its own completion pulse; ignore it there.
    assign i_req_eff = bus.i_req & ~i_rvalid_q;
    assign d_req_eff = bus.d_req & ~d_ack_q;
    assign i_match   = stream_valid_q && ({bus.i_addr[23:2], 2'b00} == next_addr_q);
    assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        addr_d         = addr_q;
        next_addr_d    = next_addr_q;
        we_d           = we_q;
        is_instr_d     = is_instr_q;
        wdata_d        = wdata_q;
        stream_valid_d = stream_valid_q;
        idle_cnt_d     = idle_cnt_q;
        i_rdata_d      = i_rdata_q;
        d_rdata_d      = d_rdata_q;
        cont_d         = 1'b0;
        i_rvalid_d     = 1'b0;
        d_ack_d        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (d_req_eff) begin
                    addr_d     = {bus.d_addr[23:2], 2'b00};
                    we_d       = bus.d_we;
                    wdata_d    = bus.d_wdata;
                    is_instr_d = 1'b0;
                    state_d    = StIssue;
                end else if (i_req_eff) begin
                    addr_d     = {bus.i_addr[23:2], 2'b00};
                    we_d       = 1'b0;
                    is_instr_d = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: state_d = is_instr_q ? StWaitI : StWaitD;
            StWaitI: begin
                if (done_edge) begin
                    i_rdata_d      = bus.m_data_out;
                    i_rvalid_d     = 1'b1;
                    next_addr_d    = addr_q + 24'd4;
                    stream_valid_d = 1'b1;
                    idle_cnt_d     = '0;
                    state_d        = StStream;
                end
            end
            StWaitD: begin
                if (done_edge) begin
                    if (!we_q) d_rdata_d = bus.m_data_out;
                    d_ack_d = 1'b1;
                    state_d = StIdle;
                end
            end
            StStream: begin
                if (d_req_eff) begin
                    addr_d     = {bus.d_addr[23:2], 2'b00};
                    we_d       = bus.d_we;
                    wdata_d    = bus.d_wdata;
                    is_instr_d = 1'b0;
                    target_d   = TgtData;
                    idle_cnt_d = '0;
                    state_d    = StStop;
                end else if (i_req_eff && i_match) begin
                    addr_d     = next_addr_q;
                    we_d       = 1'b0;
                    is_instr_d = 1'b1;
                    cont_d     = 1'b1;
                    idle_cnt_d = '0;
                    state_d    = StWaitI;
                end else if (i_req_eff) begin
                    addr_d     = {bus.i_addr[23:2], 2'b00};
                    we_d       = 1'b0;
                    is_instr_d = 1'b1;
                    target_d   = TgtInstr;
                    idle_cnt_d = '0;
                    state_d    = StStop;
                end else if (idle_cnt_q == CntW'(STREAM_IDLE_MAX - 1)) begin
                    target_d   = TgtNone;
                    idle_cnt_d = '0;
                    state_d    = StStop;
                end else begin
                    idle_cnt_d = idle_cnt_q + 1'b1;
                end
            end
            StStop: begin
                stream_valid_d = 1'b0;
                target_d       = TgtNone;
                state_d        = (target_q == TgtNone) ? StIdle : StIssue;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            target_q       <= TgtNone;
            done_q         <= 1'b0;
            addr_q         <= '0;
            next_addr_q    <= '0;
            we_q           <= 1'b0;
            is_instr_q     <= 1'b0;
            wdata_q        <= '0;
            stream_valid_q <= 1'b0;
            idle_cnt_q     <= '0;
            cont_q         <= 1'b0;
            i_rdata_q      <= '0;
            d_rdata_q      <= '0;
            i_rvalid_q     <= 1'b0;
            d_ack_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            done_q         <= bus.m_done;
            addr_q         <= addr_d;
            next_addr_q    <= next_addr_d;
            we_q           <= we_d;
            is_instr_q     <= is_instr_d;
            wdata_q        <= wdata_d;
            stream_valid_q <= stream_valid_d;
            idle_cnt_q     <= idle_cnt_d;
            cont_q         <= cont_d;
            i_rdata_q      <= i_rdata_d;
            d_rdata_q      <= d_rdata_d;
            i_rvalid_q     <= i_rvalid_d;
            d_ack_q        <= d_ack_d;
        end
    end

    assign bus.m_start        = (state_q == StIssue);
    assign bus.m_stop         = (state_q == StStop);
    assign bus.m_cont         = cont_q;
    assign bus.m_write_enable = we_q;
    assign bus.m_is_instr     = is_instr_q;
    assign bus.m_addr         = addr_q;
    assign bus.m_data_len     = 6'd32;
    assign bus.m_data_in      = wdata_q;
    assign bus.i_rdata        = i_rdata_q;
    assign bus.i_rvalid       = i_rvalid_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.d_ack          = d_ack_q;
endmodule
